// File: rtl/sar_adc_ctrl.sv
// Successive-approximation controller for the R2R-DAC / comparator ADC front end.
// Handles sample-and-hold timing, per-bit DAC settling, channel selection and round-robin scanning.
module sar_adc_ctrl #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 1,
  parameter int SAMPLE_CYCLES = 2,
  parameter int NUM_CH        = 4,
  parameter bit INVERT_DAC    = 1'b1,
  localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CH_W-1:0]  ch_req,
  input  logic             cont,
  input  logic             abort,
  input  logic             comp,
  output logic [WIDTH-1:0] dac_out,
  output logic             sample,
  output logic [CH_W-1:0]  ch_sel,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic [CH_W-1:0]  result_ch,
  output logic             result_valid
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SAMPLE = 2'd1;
  localparam logic [1:0] S_CONV   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam int               IDX_W     = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_MSB   = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [3:0]       SETTLE_L  = 4'(SETTLE_CYCLES);
  localparam logic [7:0]       SAMP_LAST = 8'(SAMPLE_CYCLES - 1);
  localparam logic [WIDTH-1:0] MSB_CODE  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CH_W:0]    NUM_CH_L  = (CH_W+1)'(NUM_CH);
  localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(NUM_CH - 1);
  localparam logic [CH_W-1:0]  CH_ONE    = CH_W'(1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] trial_q, trial_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [3:0]       settle_q, settle_d;
  logic [7:0]       samp_cnt_q, samp_cnt_d;
  logic [CH_W-1:0]  ch_sel_q, ch_sel_d;
  logic [CH_W-1:0]  scan_ptr_q, scan_ptr_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CH_W-1:0]  result_ch_q, result_ch_d;
  logic             result_valid_q, result_valid_d;

  logic [CH_W-1:0]  ch_clamped;
  logic [CH_W-1:0]  next_ptr;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d        = state_q;
    trial_d        = trial_q;
    idx_d          = idx_q;
    settle_d       = settle_q;
    samp_cnt_d     = samp_cnt_q;
    ch_sel_d       = ch_sel_q;
    scan_ptr_d     = scan_ptr_q;
    result_d       = result_q;
    result_ch_d    = result_ch_q;
    result_valid_d = 1'b0;

    ch_clamped = ({1'b0, ch_req} >= NUM_CH_L) ? '0 : ch_req;
    next_ptr   = (ch_sel_q == LAST_CH) ? '0 : ch_sel_q + CH_ONE;

    case (state_q)
      S_IDLE: begin
        if (!abort) begin
          if (cont) begin
            state_d    = S_SAMPLE;
            ch_sel_d   = scan_ptr_q;
            samp_cnt_d = SAMP_LAST;
          end else if (start) begin
            state_d    = S_SAMPLE;
            ch_sel_d   = ch_clamped;
            samp_cnt_d = SAMP_LAST;
          end
        end
      end
      S_SAMPLE: begin
        if (samp_cnt_q == 8'd0) begin
          state_d  = S_CONV;
          trial_d  = MSB_CODE;
          idx_d    = IDX_MSB;
          settle_d = SETTLE_L;
        end else begin
          samp_cnt_d = samp_cnt_q - 8'd1;
        end
      end
      S_CONV: begin
        if (settle_q != 4'd0) begin
          settle_d = settle_q - 4'd1;
        end else begin
          // Decide the current bit and, in the same cycle, put the next trial bit on the DAC.
          trial_d[idx_q] = comp;
          if (idx_q != '0) begin
            trial_d[idx_q - IDX_ONE] = 1'b1;
            idx_d    = idx_q - IDX_ONE;
            settle_d = SETTLE_L;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        result_d       = trial_q;
        result_ch_d    = ch_sel_q;
        result_valid_d = 1'b1;
        trial_d        = '0;
        scan_ptr_d     = next_ptr;
        if (cont) begin
          state_d    = S_SAMPLE;
          ch_sel_d   = next_ptr;
          samp_cnt_d = SAMP_LAST;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything, including publishing a finished result.
    if (abort && (state_q != S_IDLE)) begin
      state_d        = S_IDLE;
      trial_d        = '0;
      scan_ptr_d     = scan_ptr_q;
      result_d       = result_q;
      result_ch_d    = result_ch_q;
      result_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      trial_q        <= '0;
      idx_q          <= '0;
      settle_q       <= '0;
      samp_cnt_q     <= '0;
      ch_sel_q       <= '0;
      scan_ptr_q     <= '0;
      result_q       <= '0;
      result_ch_q    <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      trial_q        <= trial_d;
      idx_q          <= idx_d;
      settle_q       <= settle_d;
      samp_cnt_q     <= samp_cnt_d;
      ch_sel_q       <= ch_sel_d;
      scan_ptr_q     <= scan_ptr_d;
      result_q       <= result_d;
      result_ch_q    <= result_ch_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign dac_out      = INVERT_DAC ? ~trial_q : trial_q;
  assign sample       = (state_q == S_SAMPLE);
  assign busy         = (state_q != S_IDLE);
  assign ch_sel       = ch_sel_q;
  assign result       = result_q;
  assign result_ch    = result_ch_q;
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Directed bench for sar_adc_ctrl: single-shot vectors, continuous scan, abort, reset, and a 12-bit build.
// A behavioural comparator closes the loop around each DUT instance.
module tb_sar_adc_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic       start, cont, abort, comp;
  logic [1:0] ch_req;
  logic [7:0] dac_out, result;
  logic       sample, busy, result_valid;
  logic [1:0] ch_sel, result_ch;

  // 12-bit, no settle wait, non-inverting DAC, single channel
  logic        start12, cont12, abort12, comp12;
  logic        ch_req12;
  logic [11:0] dac12, result12;
  logic        sample12, busy12, result_valid12;
  logic        ch_sel12, result_ch12;

  sar_adc_ctrl u_dut (
    .clk(clk), .reset(reset), .start(start), .ch_req(ch_req), .cont(cont), .abort(abort),
    .comp(comp), .dac_out(dac_out), .sample(sample), .ch_sel(ch_sel), .busy(busy),
    .result(result), .result_ch(result_ch), .result_valid(result_valid)
  );

  sar_adc_ctrl #(.WIDTH(12), .SETTLE_CYCLES(0), .SAMPLE_CYCLES(2), .NUM_CH(1), .INVERT_DAC(1'b0)) u_dut12 (
    .clk(clk), .reset(reset), .start(start12), .ch_req(ch_req12), .cont(cont12), .abort(abort12),
    .comp(comp12), .dac_out(dac12), .sample(sample12), .ch_sel(ch_sel12), .busy(busy12),
    .result(result12), .result_ch(result_ch12), .result_valid(result_valid12)
  );

  // Comparator models: keep the bit when the analog value is at or above the DAC level.
  logic [7:0]  model_val, model_eff, trial_seen;
  logic        cont_model;
  logic [11:0] model_val12;
  assign trial_seen = ~dac_out;
  assign model_eff  = cont_model ? (8'h10 + {6'd0, ch_sel}) : model_val;
  assign comp       = (trial_seen <= model_eff);
  assign comp12     = (dac12 <= model_val12);

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0] ch;
    logic [7:0] val;
    logic [7:0] exp_res;
  } vec_t;

  vec_t vecs [4];

  task automatic run_single(input logic [1:0] ch, input logic [7:0] val, input logic [7:0] exp_res);
    int lat;
    int samp;
    logic [7:0] inv_res;
    inv_res   = ~exp_res;
    model_val = val;
    ch_req    = ch;
    start     = 1'b1;
    step();
    start = 1'b0;
    check("busy_after_accept", busy, 1);
    check("ch_sel_single", ch_sel, ch);
    samp = sample ? 1 : 0;
    lat  = 0;
    do begin
      step();
      lat++;
      if (sample) samp++;
      if (lat == 2)  check("msb_trial_dac", dac_out, 8'h7F);
      if (lat == 18) check("final_trial_dac", dac_out, inv_res);
    end while (!result_valid && lat < 40);
    check("single_latency", lat, 19);
    check("sample_cycles", samp, 2);
    check("single_result", result, exp_res);
    check("single_result_ch", result_ch, ch);
    check("busy_at_valid", busy, 0);
    step();
    check("valid_one_cycle", result_valid, 0);
    check("idle_dac", dac_out, 8'hFF);
  endtask

  initial begin
    int lat;
    bit saw_idle;
    bit saw_valid;
    logic [7:0] exp_r;

    vecs[0] = '{ch: 2'd2, val: 8'hA5, exp_res: 8'hA5};
    vecs[1] = '{ch: 2'd1, val: 8'h00, exp_res: 8'h00};
    vecs[2] = '{ch: 2'd0, val: 8'h5A, exp_res: 8'h5A};
    vecs[3] = '{ch: 2'd3, val: 8'hFF, exp_res: 8'hFF};

    reset = 1'b0;
    start = 1'b0; cont = 1'b0; abort = 1'b0; ch_req = '0;
    start12 = 1'b0; cont12 = 1'b0; abort12 = 1'b0; ch_req12 = 1'b0;
    model_val = 8'h00; model_val12 = 12'h000; cont_model = 1'b0;
    #12;
    check("rst_dac", dac_out, 8'hFF);
    check("rst_busy", busy, 0);
    check("rst_sample", sample, 0);
    check("rst_valid", result_valid, 0);
    check("rst_result", result, 0);
    check("rst_ch_sel", ch_sel, 0);
    check("rst_dac12", dac12, 0);
    @(negedge clk);
    reset = 1'b1;
    step();

    // Single-shot vectors; the last one uses channel 3 so the scan pointer wraps to 0.
    for (int i = 0; i < 4; i++) run_single(vecs[i].ch, vecs[i].val, vecs[i].exp_res);

    // Continuous scan: five back-to-back results, then drop cont during the sixth.
    cont_model = 1'b1;
    cont = 1'b1;
    step();
    for (int k = 0; k < 6; k++) begin
      lat = 0;
      saw_idle = 1'b0;
      do begin
        step();
        lat++;
        if (!busy && !result_valid) saw_idle = 1'b1;
      end while (!result_valid && lat < 40);
      exp_r = 8'h10 + 8'(k % 4);
      check("cont_latency", lat, 19);
      check("cont_result", result, exp_r);
      check("cont_result_ch", result_ch, k % 4);
      if (k < 5) begin
        check("cont_no_gap", saw_idle, 0);
        check("cont_busy_at_valid", busy, 1);
      end else begin
        check("cont_drop_idle", busy, 0);
      end
      if (k == 4) cont = 1'b0;
    end
    cont_model = 1'b0;
    step();

    // Abort at bit 3 of a conversion; the previous result (8'h11) must survive.
    model_val = 8'hA5;
    ch_req = 2'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (10) step();
    check("abort_pre_busy", busy, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_valid", result_valid, 0);
    check("abort_result", result, 8'h11);
    check("abort_dac", dac_out, 8'hFF);
    saw_valid = 1'b0;
    repeat (4) begin
      step();
      if (result_valid || busy) saw_valid = 1'b1;
    end
    check("abort_quiet", saw_valid, 0);

    // Abort in IDLE blocks acceptance of a coincident start.
    abort = 1'b1; start = 1'b1; ch_req = 2'd2;
    step();
    abort = 1'b0; start = 1'b0;
    check("abort_idle_block", busy, 0);
    run_single(2'd1, 8'h3C, 8'h3C);

    // start during busy is ignored; async reset mid-CONV clears everything.
    model_val = 8'h77;
    ch_req = 2'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (2) step();
    ch_req = 2'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_ignored_ch", ch_sel, 2);
    check("start_ignored_busy", busy, 1);
    repeat (4) step();
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_dac", dac_out, 8'hFF);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_sample", sample, 0);
    check("mid_rst_valid", result_valid, 0);
    check("mid_rst_result", result, 0);
    check("mid_rst_result_ch", result_ch, 0);
    check("mid_rst_ch_sel", ch_sel, 0);
    @(negedge clk);
    reset = 1'b1;
    saw_valid = 1'b0;
    repeat (5) begin
      step();
      if (result_valid || busy) saw_valid = 1'b1;
    end
    check("post_rst_quiet", saw_valid, 0);

    // 12-bit build: ch_req=1 is out of range for one channel and must map to channel 0.
    model_val12 = 12'h5A3;
    ch_req12 = 1'b1;
    start12 = 1'b1;
    step();
    start12 = 1'b0;
    check("w12_busy", busy12, 1);
    check("w12_ch_clamp", ch_sel12, 0);
    lat = 0;
    do begin
      step();
      lat++;
      if (lat == 2) check("w12_msb_dac", dac12, 12'h800);
    end while (!result_valid12 && lat < 40);
    check("w12_latency", lat, 15);
    check("w12_result", result12, 12'h5A3);
    check("w12_result_ch", result_ch12, 0);
    step();
    check("w12_valid_one_cycle", result_valid12, 0);
    check("w12_idle_dac", dac12, 12'h000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
